// File: rtl/fu_cdb_unit.sv
// Functional unit between the RS FU bus and the CDB: accepts one instruction,
// runs a single-cycle ALU op or an iterative shift-add multiply, then broadcasts.
module fu_cdb_unit #(
    parameter int DW   = 8,
    parameter int TAGW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 futransmit,
    input  logic [DW-1:0]        operand,
    input  logic [DW-1:0]        wbs,
    input  logic [1:0][DW-1:0]   depvals,
    input  logic [DW-1:0]        flag,
    input  logic [DW-1:0]        robid,
    output logic                 fuclaimed,
    output logic                 cdbreq,
    input  logic                 cdbgrant,
    output logic [TAGW-1:0]      depins,
    output logic [DW-1:0]        depinval,
    output logic [DW-1:0]        flagout,
    output logic [DW-1:0]        robidout
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        BCAST = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [TAGW-1:0]     tag_q;
    logic [DW-1:0]       rob_q;
    logic [DW-1:0]       res_q;
    logic                carry_q;
    logic [2*DW-1:0]     prod_q;
    logic [2*DW-1:0]     mcand_q;
    logic [DW-1:0]       mplier_q;
    logic [CW-1:0]       cnt_q;

    logic [2:0]          opcode;
    logic                is_mul;
    logic [DW-1:0]       op_a, op_b;
    logic                cin;
    logic [2:0]          shamt;
    logic [DW:0]         wide;
    logic [DW-1:0]       alu_res;
    logic                alu_carry;
    logic [2*DW-1:0]     prod_add;
    logic                mul_last;
    logic                unused_bits;

    assign opcode   = operand[2:0];
    assign is_mul   = (opcode == 3'd7);
    assign op_a     = depvals[0];
    assign op_b     = depvals[1];
    assign cin      = flag[0];
    assign shamt    = op_b[2:0];
    assign prod_add = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign mul_last = (cnt_q == CW'(1));

    assign unused_bits = ^{flag[DW-1:1], operand[DW-1:3], wbs[DW-1:TAGW]};

    // Carry is the bit that falls off the DW-wide result; for SUB it is the borrow.
    always_comb begin
        wide      = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (opcode)
            3'd0: begin
                wide      = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, cin};
                alu_res   = wide[DW-1:0];
                alu_carry = wide[DW];
            end
            3'd1: begin
                wide      = {1'b0, op_a} - {1'b0, op_b} - {{DW{1'b0}}, cin};
                alu_res   = wide[DW-1:0];
                alu_carry = wide[DW];
            end
            3'd2: alu_res = op_a & op_b;
            3'd3: alu_res = op_a | op_b;
            3'd4: alu_res = op_a ^ op_b;
            3'd5: begin
                wide      = {1'b0, op_a} << shamt;
                alu_res   = wide[DW-1:0];
                alu_carry = wide[DW];
            end
            3'd6: begin
                wide      = {op_a, 1'b0} >> shamt;
                alu_res   = wide[DW:1];
                alu_carry = wide[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (futransmit) state_nxt = is_mul ? MUL : BCAST;
            MUL:     if (mul_last)   state_nxt = BCAST;
            BCAST:   if (cdbgrant)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath only loads in IDLE, so futransmit while claimed cannot disturb it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q    <= '0;
            rob_q    <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (futransmit) begin
                        tag_q <= wbs[TAGW-1:0];
                        rob_q <= robid;
                        if (is_mul) begin
                            prod_q   <= '0;
                            mcand_q  <= {{DW{1'b0}}, op_a};
                            mplier_q <= op_b;
                            cnt_q    <= CW'(DW);
                            res_q    <= '0;
                            carry_q  <= 1'b0;
                        end else begin
                            res_q   <= alu_res;
                            carry_q <= alu_carry;
                        end
                    end
                end
                MUL: begin
                    prod_q   <= prod_add;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    if (mul_last) begin
                        res_q   <= prod_add[DW-1:0];
                        carry_q <= |prod_add[2*DW-1:DW];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fuclaimed = (state != IDLE);
        cdbreq    = (state == BCAST);
        depins    = cdbreq ? tag_q : '0;
        depinval  = cdbreq ? res_q : '0;
        robidout  = cdbreq ? rob_q : '0;
        flagout   = cdbreq ? {{(DW-2){1'b0}}, carry_q, (res_q == '0)} : '0;
    end

endmodule

// File: tb/tb_fu_cdb_unit.sv
// Directed plus randomized bench for fu_cdb_unit; expected values come from an
// integer-arithmetic model of each opcode.
module tb_fu_cdb_unit;

    logic             clk;
    logic             rst;
    logic             futransmit;
    logic [7:0]       operand;
    logic [7:0]       wbs;
    logic [1:0][7:0]  depvals;
    logic [7:0]       flag;
    logic [7:0]       robid;
    logic             fuclaimed;
    logic             cdbreq;
    logic             cdbgrant;
    logic [3:0]       depins;
    logic [7:0]       depinval;
    logic [7:0]       flagout;
    logic [7:0]       robidout;

    int total = 0;
    int bad   = 0;

    fu_cdb_unit #(.DW(8), .TAGW(4)) dut (
        .clk(clk), .rst(rst), .futransmit(futransmit), .operand(operand),
        .wbs(wbs), .depvals(depvals), .flag(flag), .robid(robid),
        .fuclaimed(fuclaimed), .cdbreq(cdbreq), .cdbgrant(cdbgrant),
        .depins(depins), .depinval(depinval), .flagout(flagout), .robidout(robidout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic checkBus(input string name, input logic req, input logic claim,
                            input logic [3:0] tg, input logic [7:0] val,
                            input logic [7:0] fl, input logic [7:0] rb);
        checkOutput({name, ".req"},   32'(cdbreq),    32'(req));
        checkOutput({name, ".claim"}, 32'(fuclaimed), 32'(claim));
        checkOutput({name, ".tag"},   32'(depins),    32'(tg));
        checkOutput({name, ".val"},   32'(depinval),  32'(val));
        checkOutput({name, ".flag"},  32'(flagout),   32'(fl));
        checkOutput({name, ".rob"},   32'(robidout),  32'(rb));
    endtask

    task automatic checkIdle(input string name);
        checkBus(name, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00);
    endtask

    // Presents an instruction for exactly one edge; returns after that edge.
    task automatic applyStimulus(input int op, input int a, input int b, input int cin,
                                 input int tag, input int rob);
        operand    = {5'(op >> 3), 3'(op)};
        depvals[0] = 8'(a);
        depvals[1] = 8'(b);
        flag       = {7'($urandom), 1'(cin)};
        wbs        = {4'($urandom), 4'(tag)};
        robid      = 8'(rob);
        futransmit = 1'b1;
        tick();
        futransmit = 1'b0;
        operand    = 8'($urandom);
        depvals    = 16'($urandom);
    endtask

    // Returns {carry, result} for one operation.
    function automatic logic [8:0] model(input int op, input int a, input int b, input int cin);
        int r, c, s;
        s = b % 8;
        c = 0;
        case (op)
            0: begin r = a + b + cin; c = (r > 255) ? 1 : 0; end
            1: begin r = a - b - cin; c = (r < 0) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a << s; c = (s == 0) ? 0 : ((a >> (8 - s)) & 1); end
            6: begin r = a >> s; c = (s == 0) ? 0 : ((a >> (s - 1)) & 1); end
            default: begin r = a * b; c = (r > 255) ? 1 : 0; end
        endcase
        return {1'(c), 8'(r)};
    endfunction

    function automatic logic [7:0] flagsOf(input logic [8:0] m);
        return {6'b0, m[8], (m[7:0] == 8'h00)};
    endfunction

    task automatic grantAndCheckIdle(input string name);
        cdbgrant = 1'b1;
        tick();
        cdbgrant = 1'b0;
        checkIdle(name);
    endtask

    initial begin
        logic [8:0] m;
        logic [7:0] fl;
        int op, a, b, cin, tag, rob, lat, dly;

        rst        = 1'b0;
        futransmit = 1'b1;
        cdbgrant   = 1'b1;
        operand    = 8'($urandom);
        wbs        = 8'($urandom);
        depvals    = 16'($urandom);
        flag       = 8'($urandom);
        robid      = 8'($urandom);
        tick();
        tick();
        checkIdle("reset");
        futransmit = 1'b0;
        cdbgrant   = 1'b0;
        rst        = 1'b1;
        tick();
        checkIdle("post_reset");

        $display("[TB] ADD");
        applyStimulus(0, 'h0F, 'h01, 0, 3, 'h01);
        checkBus("add", 1'b1, 1'b1, 4'h3, 8'h10, 8'h00, 8'h01);
        grantAndCheckIdle("add_done");

        $display("[TB] SUB wrap and grant stall");
        applyStimulus(1, 'h00, 'h01, 0, 7, 'h22);
        checkBus("sub", 1'b1, 1'b1, 4'h7, 8'hFF, 8'h02, 8'h22);
        for (int i = 0; i < 5; i++) begin
            futransmit = (i == 2);
            operand    = 8'h00;
            depvals    = 16'h0101;
            tick();
            checkBus("sub_stall", 1'b1, 1'b1, 4'h7, 8'hFF, 8'h02, 8'h22);
        end
        futransmit = 1'b0;
        grantAndCheckIdle("sub_done");

        $display("[TB] MUL");
        applyStimulus(7, 'h10, 'h11, 0, 5, 'h33);
        for (int i = 0; i < 8; i++) begin
            checkOutput("mul_busy.claim", 32'(fuclaimed), 32'd1);
            checkOutput("mul_busy.req",   32'(cdbreq),    32'd0);
            if (i < 7) tick();
        end
        tick();
        checkBus("mul", 1'b1, 1'b1, 4'h5, 8'h10, 8'h02, 8'h33);
        grantAndCheckIdle("mul_done");

        $display("[TB] reset mid-MUL");
        applyStimulus(7, 'hFF, 'hFF, 0, 9, 'h44);
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkIdle("mul_reset");
        rst = 1'b1;
        applyStimulus(0, 'h7F, 'h80, 1, 2, 'h55);
        checkBus("add_after_reset", 1'b1, 1'b1, 4'h2, 8'h00, 8'h03, 8'h55);
        grantAndCheckIdle("add_after_reset_done");

        $display("[TB] tag 0 and back-to-back");
        applyStimulus(4, 'hAA, 'hAA, 0, 0, 'h66);
        checkBus("xor_tag0", 1'b1, 1'b1, 4'h0, 8'h00, 8'h01, 8'h66);
        operand    = 8'h05;
        depvals[0] = 8'h81;
        depvals[1] = 8'h01;
        flag       = 8'h00;
        wbs        = 8'h0C;
        robid      = 8'h77;
        futransmit = 1'b1;
        cdbgrant   = 1'b1;
        tick();
        cdbgrant = 1'b0;
        checkIdle("grant_e1");
        tick();
        futransmit = 1'b0;
        checkBus("shl_e2", 1'b1, 1'b1, 4'hC, 8'h02, 8'h02, 8'h77);
        grantAndCheckIdle("shl_done");

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            op  = (n < 8) ? n : int'($urandom_range(0, 7));
            a   = int'($urandom_range(0, 255));
            b   = int'($urandom_range(0, 255));
            cin = int'($urandom_range(0, 1));
            tag = int'($urandom_range(0, 15));
            rob = int'($urandom_range(0, 255));
            m   = model(op, a, b, (op <= 1) ? cin : 0);
            fl  = flagsOf(m);
            applyStimulus(op, a, b, cin, tag, rob);
            lat = 0;
            while (!cdbreq && lat < 20) begin
                tick();
                lat++;
            end
            checkOutput("rnd.latency", 32'(lat), (op == 7) ? 32'd8 : 32'd0);
            dly = int'($urandom_range(0, 3));
            for (int d = 0; d < dly; d++) tick();
            checkBus("rnd", 1'b1, 1'b1, 4'(tag), m[7:0], fl, 8'(rob));
            grantAndCheckIdle("rnd_done");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fu_cdb_unit.md
# fu_cdb_unit

Functional unit that sits on the consumer side of the reservation-station FU bus and the producer side of the common data bus (CDB). It accepts one issued instruction at a time from the daisy-chained RS array, executes it (single-cycle ALU or iterative multiply), and broadcasts the result tag and value on the CDB that the RSes snoop. While it holds an instruction, it drives the FU-bus claim so no RS transmits.

## Interface
- DW, 8, data width of operands, results and ROB id
- TAGW, 4, CDB tag width; tag 0 means "no tag"
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- futransmit  in  1  RS is presenting an instruction this cycle
- operand  in  DW  bits[2:0] opcode, bits[DW-1:3] ignored
- wbs  in  DW  bits[TAGW-1:0] destination tag, upper bits ignored
- depvals  in  2xDW  source values A = depvals[0], B = depvals[1]
- flag  in  DW  bit0 carry-in for ADD/SUB, other bits ignored
- robid  in  DW  ROB entry id, carried through unchanged
- fuclaimed  out  1  FU bus busy; RSes must not transmit while high
- cdbreq  out  1  result valid, requesting the CDB
- cdbgrant  in  1  CDB arbiter grant
- depins  out  TAGW  broadcast tag, 0 when cdbreq low
- depinval  out  DW  broadcast value, 0 when cdbreq low
- flagout  out  DW  {DW-2 zeros, carry, zero} of the result, 0 when cdbreq low
- robidout  out  DW  ROB id of the result, 0 when cdbreq low

## Operation
- States: IDLE, MUL, BCAST. fuclaimed = (state != IDLE).
- IDLE: at an edge with futransmit=1, latch tag, robid, A, B and carry-in.
  - Opcodes 0-6 (ADD, SUB, AND, OR, XOR, SHL, SHR): compute the result combinationally from the inputs, register it, and go to BCAST.
  - Opcode 7 (MUL): go to MUL.
- Arithmetic, with result width DW:
  - ADD: A+B+cin.
  - SUB: A-B-cin, where carry = borrow out.
  - SHL/SHR: shift A by B[2:0], logical; carry = last bit shifted out, or 0 if the shift amount is 0.
  - AND/OR/XOR: carry = 0.
  - zero = (result == 0).
- MUL: shift-add, one multiplier bit per cycle for exactly DW cycles, using a counter of DW down to 1. The result is the low DW bits of A*B with carry = 1 if any high-half bit is nonzero. Then go to BCAST.
- BCAST: cdbreq=1, and depins, depinval, flagout, robidout are driven from registers and held stable. At an edge with cdbgrant=1, go to IDLE.
- Tag 0: the unit still requests the CDB (ROB completion via robidout) with depins=0.
- futransmit while fuclaimed=1 is a protocol violation. It is ignored, and no state or register changes.
- cdbgrant outside BCAST is ignored.
- Reset (rst=0 at an edge) from any state, including mid-MUL or mid-BCAST:
  - State goes to IDLE and the in-flight instruction is dropped.
  - fuclaimed=0, cdbreq=0, depins=0, depinval=0, flagout=0, robidout=0.
  - MUL counter and all internal registers are cleared.

## Timing
- Accept edge E0 is the edge where futransmit=1 and state=IDLE.
- ALU op: cdbreq=1 and fuclaimed=1 after E0. The earliest grant edge is E1, and fuclaimed drops after E1. The earliest next accept is E2.
- MUL: fuclaimed=1 after E0; MUL runs for edges E1..E8 (DW=8); cdbreq=1 after E8. The earliest grant is at E9.
- Grant held low: cdbreq and all outputs stay constant indefinitely, and fuclaimed stays high.
- Simultaneous grant and futransmit at the same edge in BCAST: the grant is taken and futransmit is ignored, because the RS saw fuclaimed=1.
- All outputs are registered or decoded only from state, with no input-to-output combinational path.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs -> all outputs 0, state IDLE. Then release.
- ADD: accept op0 with A=8'h0F, B=8'h01, cin=0, tag 3, robid 8'h01. -> The cycle after acceptance shows cdbreq=1, depins=3, depinval=8'h10, flagout=0, robidout=8'h01. Assert grant -> next cycle cdbreq=0, depins=0, fuclaimed=0.
- SUB wrap, then grant stall:
  - Op1 with A=8'h00, B=8'h01, tag 7 -> depinval=8'hFF, flagout=8'h02.
  - Hold cdbgrant=0 for 5 cycles -> outputs stable and fuclaimed=1 throughout.
  - Pulse futransmit during the stall -> ignored.
- MUL: A=8'h10, B=8'h11, tag 5 -> fuclaimed=1 for 8 cycles with cdbreq=0, then cdbreq=1 with depinval=8'h10 and flagout=8'h02 (high half 8'h01).
- Reset mid-MUL: drop rst at cycle 4 of a MUL -> after that edge fuclaimed=0 and cdbreq=0. After release, a new ADD completes normally with the correct value.
- Tag 0 and back-to-back:
  - XOR with A=B=8'hAA and tag 0 -> cdbreq=1, depins=0, depinval=0, flagout=8'h01.
  - Grant at the first possible edge and present the next op at E2 -> accepted at E2.
